// File: rtl/rtc_pkg.sv
// rtc_pkg
//   Shared definitions for the RTC field editor:
//   - state_t     : editor state enumeration
//   - FIELD_MIN   : lowest legal BCD value per field index 0..7
//   - FIELD_MAX   : highest legal BCD value per field index 0..7
//   Field order: sec, min, hour, date, month, year, day-of-week, week.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EDIT,
    ST_COMMIT
  } state_t;

  localparam int MAX_FIELDS = 8;

  localparam logic [7:0] FIELD_MIN [MAX_FIELDS] = '{
    8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01
  };

  localparam logic [7:0] FIELD_MAX [MAX_FIELDS] = '{
    8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 8'h07, 8'h53
  };

endpackage

// File: rtl/bcd_step.sv
// bcd_step
//   Combinational two-digit BCD increment/decrement with wrap-around.
//   Ports:
//     value      in  8  current packed BCD value
//     min        in  8  lowest legal value (BCD)
//     max        in  8  highest legal value (BCD)
//     dir        in  1  1 = increment, 0 = decrement
//     next_value out 8  stepped value; an invalid input yields min
module bcd_step (
  input  logic [7:0] value,
  input  logic [7:0] min,
  input  logic [7:0] max,
  input  logic       dir,
  output logic [7:0] next_value
);

  logic valid;

  // For well-formed BCD, plain binary ordering equals decimal ordering,
  // so the range check can compare the packed bytes directly.
  assign valid = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) &&
                 (value >= min) && (value <= max);

  always_comb begin
    next_value = min;
    if (valid) begin
      if (dir) begin
        if (value == max) begin
          next_value = min;
        end else if (value[3:0] == 4'd9) begin
          next_value = {value[7:4] + 4'd1, 4'd0};
        end else begin
          next_value = {value[7:4], value[3:0] + 4'd1};
        end
      end else begin
        if (value == min) begin
          next_value = max;
        end else if (value[3:0] == 4'd0) begin
          next_value = {value[7:4] - 4'd1, 4'd9};
        end else begin
          next_value = {value[7:4], value[3:0] - 4'd1};
        end
      end
    end
  end

endmodule

// File: rtl/rtc_field_editor.sv
// rtc_field_editor
//   Button-driven editor for RTC time/date fields. On an Escribir rising
//   edge it snapshots rd_data into a shadow copy, lets the user pick a
//   field (left/right) and step it (up/down), and issues one register
//   write per step through a wr_req/wr_ack handshake.
//   Ports:
//     clk            in   1            clock, rising edge
//     Reset          in   1            asynchronous active-high reset
//     Escribir       in   1            edit-mode enable level (async)
//     push_arriba    in   1            increment button (async)
//     push_abajo     in   1            decrement button (async)
//     push_izquierda in   1            next field button (async)
//     push_derecha   in   1            previous field button (async)
//     rd_data        in   NUM_FIELDS*8 current RTC values, field 0 in [7:0]
//     wr_ack         in   1            one-cycle write acknowledge
//     address        out  8            register address of pending write
//     data_mod       out  8            BCD data of pending write
//     wr_req         out  1            write request, held until wr_ack
//     field_idx      out  3            currently selected field
//     fields_out     out  NUM_FIELDS*8 shadow copy of all fields
//     editing        out  1            high whenever not idle
module rtc_field_editor
  import rtc_pkg::*;
#(
  parameter int         NUM_FIELDS  = 4,
  parameter logic [7:0] BASE_ADDR   = 8'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    Escribir,
  input  logic                    push_arriba,
  input  logic                    push_abajo,
  input  logic                    push_izquierda,
  input  logic                    push_derecha,
  input  logic [NUM_FIELDS*8-1:0] rd_data,
  input  logic                    wr_ack,
  output logic [7:0]              address,
  output logic [7:0]              data_mod,
  output logic                    wr_req,
  output logic [2:0]              field_idx,
  output logic [NUM_FIELDS*8-1:0] fields_out,
  output logic                    editing
);

  localparam int         NUM_INPUTS = 5;
  localparam logic [2:0] LAST_IDX   = 3'(NUM_FIELDS - 1);
  localparam logic [1:0] SETTLE     = 2'(SYNC_STAGES);

  // Bit 0 is Escribir, bits 1..4 are up, down, left, right.
  logic [NUM_INPUTS-1:0] raw_in;
  logic [NUM_INPUTS-1:0] level;
  logic [NUM_INPUTS-1:0] hist;
  logic [NUM_INPUTS-1:0] rise;

  assign raw_in = {push_derecha, push_izquierda, push_abajo, push_arriba, Escribir};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   hist_reg;

      always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
          sync_reg <= '0;
          hist_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
          hist_reg <= sync_reg[SYNC_STAGES-1];
        end
      end

      assign level[gi] = sync_reg[SYNC_STAGES-1];
      assign hist[gi]  = hist_reg;
    end
  endgenerate

  assign rise = level & ~hist;

  // Button priority: up > down > left > right; losers are discarded.
  logic ev_up, ev_down, ev_left, ev_right;
  assign ev_up    = rise[1];
  assign ev_down  = rise[2] & ~rise[1];
  assign ev_left  = rise[3] & ~rise[2] & ~rise[1];
  assign ev_right = rise[4] & ~rise[3] & ~rise[2] & ~rise[1];

  // The synchroniser comes out of reset full of zeros, so a level that was
  // already high during reset would look like a fresh rising edge. Escribir
  // edges are only honoured once a genuine low has been seen after the
  // chain has refilled with real samples.
  logic [1:0] settle_reg;
  logic       esc_armed_reg;
  logic       esc_level;
  logic       esc_rise;

  assign esc_level = level[0];
  assign esc_rise  = rise[0] & esc_armed_reg;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      settle_reg    <= 2'd0;
      esc_armed_reg <= 1'b0;
    end else begin
      if (settle_reg != SETTLE) begin
        settle_reg <= settle_reg + 2'd1;
      end
      if ((settle_reg == SETTLE) && !esc_level) begin
        esc_armed_reg <= 1'b1;
      end
    end
  end

  // Editor state.
  state_t     state_reg, state_next;
  logic [2:0] field_idx_reg, field_idx_next;
  logic [7:0] address_reg, address_next;
  logic [7:0] data_mod_reg, data_mod_next;
  logic       load_en;
  logic       step_en;
  logic [7:0] sel_value;
  logic [7:0] step_value;

  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      logic [7:0] shadow_reg;

      always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
          shadow_reg <= 8'h00;
        end else if (load_en) begin
          shadow_reg <= rd_data[gi*8 +: 8];
        end else if (step_en && (field_idx_reg == 3'(gi))) begin
          shadow_reg <= step_value;
        end
      end

      assign fields_out[gi*8 +: 8] = shadow_reg;
    end
  endgenerate

  always_comb begin
    sel_value = 8'h00;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (field_idx_reg == 3'(i)) begin
        sel_value = fields_out[i*8 +: 8];
      end
    end
  end

  bcd_step u_bcd_step (
    .value      (sel_value),
    .min        (FIELD_MIN[field_idx_reg]),
    .max        (FIELD_MAX[field_idx_reg]),
    .dir        (ev_up),
    .next_value (step_value)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      field_idx_reg <= 3'd0;
      address_reg   <= BASE_ADDR;
      data_mod_reg  <= 8'h00;
    end else begin
      state_reg     <= state_next;
      field_idx_reg <= field_idx_next;
      address_reg   <= address_next;
      data_mod_reg  <= data_mod_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    field_idx_next = field_idx_reg;
    address_next   = address_reg;
    data_mod_next  = data_mod_reg;
    load_en        = 1'b0;
    step_en        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (esc_rise) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_en        = 1'b1;
        field_idx_next = 3'd0;
        state_next     = ST_EDIT;
      end
      ST_EDIT: begin
        if (!esc_level) begin
          state_next = ST_IDLE;
        end else if (ev_up || ev_down) begin
          // Shadow, write address/data and COMMIT entry share one edge.
          step_en       = 1'b1;
          address_next  = BASE_ADDR + {5'd0, field_idx_reg};
          data_mod_next = step_value;
          state_next    = ST_COMMIT;
        end else if (ev_left) begin
          field_idx_next = (field_idx_reg == LAST_IDX) ? 3'd0 : field_idx_reg + 3'd1;
        end else if (ev_right) begin
          field_idx_next = (field_idx_reg == 3'd0) ? LAST_IDX : field_idx_reg - 3'd1;
        end
      end
      ST_COMMIT: begin
        // Button events here are dropped; Escribir low is honoured only
        // once the handshake has completed.
        if (wr_ack) begin
          state_next = esc_level ? ST_EDIT : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign wr_req    = (state_reg == ST_COMMIT);
  assign editing   = (state_reg != ST_IDLE);
  assign address   = address_reg;
  assign data_mod  = data_mod_reg;
  assign field_idx = field_idx_reg;

endmodule

// File: tb/tb_rtc_field_editor.sv
// tb_rtc_field_editor
//   Directed bench for rtc_field_editor with a decimal-arithmetic reference
//   model checked against the DUT outputs every cycle, plus literal
//   expectations for each write and for key field/index values.
module tb_rtc_field_editor;

  localparam int N = 4;
  localparam int S = 2;

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_EDIT   = 2;
  localparam int P_COMMIT = 3;

  logic          clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Escribir = 1'b0;
  logic          push_arriba = 1'b0;
  logic          push_abajo = 1'b0;
  logic          push_izquierda = 1'b0;
  logic          push_derecha = 1'b0;
  logic [N*8-1:0] rd_data = '0;
  logic          wr_ack = 1'b0;
  logic [7:0]    address;
  logic [7:0]    data_mod;
  logic          wr_req;
  logic [2:0]    field_idx;
  logic [N*8-1:0] fields_out;
  logic          editing;

  always #5 clk = ~clk;

  rtc_field_editor #(
    .NUM_FIELDS  (N),
    .BASE_ADDR   (8'h21),
    .SYNC_STAGES (S)
  ) dut (
    .clk            (clk),
    .Reset          (Reset),
    .Escribir       (Escribir),
    .push_arriba    (push_arriba),
    .push_abajo     (push_abajo),
    .push_izquierda (push_izquierda),
    .push_derecha   (push_derecha),
    .rd_data        (rd_data),
    .wr_ack         (wr_ack),
    .address        (address),
    .data_mod       (data_mod),
    .wr_req         (wr_req),
    .field_idx      (field_idx),
    .fields_out     (fields_out),
    .editing        (editing)
  );

  int tests = 0;
  int fails = 0;
  int req_count = 0;
  logic prev_req = 1'b0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int MINV [8] = '{0, 0, 0, 1, 1, 0, 1, 1};
  int MAXV [8] = '{59, 59, 23, 31, 12, 99, 7, 53};

  int         m_phase;
  int         m_idx;
  logic [7:0] m_sh [N];
  logic [7:0] m_addr;
  logic [7:0] m_data;
  logic [4:0] m_pipe [S];
  logic [S-1:0] m_real;
  logic [4:0] m_hist;
  logic       m_esc_prev;

  function automatic logic [7:0] model_step(input logic [7:0] v, input int idx, input bit up);
    int hi, lo, d;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    d  = hi * 10 + lo;
    if (hi > 9 || lo > 9 || d < MINV[idx] || d > MAXV[idx]) d = MINV[idx];
    else if (up) d = (d == MAXV[idx]) ? MINV[idx] : d + 1;
    else d = (d == MINV[idx]) ? MAXV[idx] : d - 1;
    return 8'((d / 10) * 16 + (d % 10));
  endfunction

  // Inputs become visible S edges after they are sampled; an Escribir edge
  // counts only from a genuinely sampled low (a reset-filled pipe is not one).
  always @(posedge clk or posedge Reset) begin
    logic [4:0] lvl, ev;
    logic       real_l, esc_rise, nprev;
    int         nphase, nidx;
    logic [7:0] nsh [N];
    logic [7:0] naddr, ndata;
    if (Reset) begin
      m_phase    <= P_IDLE;
      m_idx      <= 0;
      for (int i = 0; i < N; i++) m_sh[i] <= 8'h00;
      m_addr     <= 8'h21;
      m_data     <= 8'h00;
      for (int i = 0; i < S; i++) m_pipe[i] <= 5'd0;
      m_real     <= '0;
      m_hist     <= 5'd0;
      m_esc_prev <= 1'b1;
    end else begin
      lvl    = m_pipe[S-1];
      real_l = m_real[S-1];
      ev     = lvl & ~m_hist;
      esc_rise = real_l && lvl[0] && !m_esc_prev;
      nprev  = real_l ? lvl[0] : m_esc_prev;
      nphase = m_phase;
      nidx   = m_idx;
      for (int i = 0; i < N; i++) nsh[i] = m_sh[i];
      naddr  = m_addr;
      ndata  = m_data;
      case (m_phase)
        P_IDLE: if (esc_rise) nphase = P_LOAD;
        P_LOAD: begin
          for (int i = 0; i < N; i++) nsh[i] = rd_data[i*8 +: 8];
          nidx   = 0;
          nphase = P_EDIT;
        end
        P_EDIT: begin
          if (!lvl[0]) nphase = P_IDLE;
          else if (ev[1] || ev[2]) begin
            nsh[m_idx] = model_step(m_sh[m_idx], m_idx, ev[1]);
            naddr  = 8'h21 + 8'(m_idx);
            ndata  = nsh[m_idx];
            nphase = P_COMMIT;
          end else if (ev[3]) nidx = (m_idx + 1) % N;
          else if (ev[4]) nidx = (m_idx + N - 1) % N;
        end
        default: if (wr_ack) nphase = lvl[0] ? P_EDIT : P_IDLE;
      endcase
      m_phase    <= nphase;
      m_idx      <= nidx;
      for (int i = 0; i < N; i++) m_sh[i] <= nsh[i];
      m_addr     <= naddr;
      m_data     <= ndata;
      m_esc_prev <= nprev;
      m_hist     <= lvl;
      for (int i = S - 1; i > 0; i--) m_pipe[i] <= m_pipe[i-1];
      m_pipe[0]  <= {push_derecha, push_izquierda, push_abajo, push_arriba, Escribir};
      m_real     <= {m_real[S-2:0], 1'b1};
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [N*8-1:0] exp_f;
    if (chk_en) begin
      for (int i = 0; i < N; i++) exp_f[i*8 +: 8] = m_sh[i];
      chk("cyc_wr_req", 32'(wr_req), 32'(m_phase == P_COMMIT));
      chk("cyc_editing", 32'(editing), 32'(m_phase != P_IDLE));
      chk("cyc_field_idx", 32'(field_idx), 32'(m_idx));
      chk("cyc_address", 32'(address), 32'(m_addr));
      chk("cyc_data_mod", 32'(data_mod), 32'(m_data));
      chk("cyc_fields_out", 32'(fields_out), 32'(exp_f));
    end
    if (wr_req && !prev_req) req_count <= req_count + 1;
    prev_req <= wr_req;
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input logic u, input logic d, input logic l, input logic r);
    push_arriba = u; push_abajo = d; push_izquierda = l; push_derecha = r;
    @(negedge clk);
    push_arriba = 0; push_abajo = 0; push_izquierda = 0; push_derecha = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!wr_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!wr_req) begin
      tests++;
      fails++;
      $display("FAIL %s: wr_req still 0 after 30 cycles, required 1", name);
    end
  endtask

  task automatic ack(input string name, input logic [7:0] ea, input logic [7:0] ed);
    wait_req(name);
    if (wr_req) begin
      chk(name, {16'd0, address, data_mod}, {16'd0, ea, ed});
      $display("[TB] write addr=%h data=%h", address, data_mod);
      wr_ack = 1'b1;
      @(negedge clk);
      wr_ack = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic enter(input logic [N*8-1:0] rd);
    int n = 0;
    Escribir = 1'b0;
    repeat (6) @(negedge clk);
    chk("leave_edit", 32'(editing), 32'd0);
    rd_data  = rd;
    Escribir = 1'b1;
    while (!editing && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!editing) begin
      tests++;
      fails++;
      $display("FAIL enter_edit: editing still 0 after 30 cycles, required 1");
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int r0;
    #1 Reset = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_address", 32'(address), 32'h21);
    chk("rst_data_mod", 32'(data_mod), 32'h00);
    chk("rst_field_idx", 32'(field_idx), 32'd0);
    chk("rst_fields", 32'(fields_out), 32'h0);
    chk("rst_editing", 32'(editing), 32'd0);
    Reset = 1'b0;
    repeat (3) @(negedge clk);

    // sec 58 -> 59 -> wrap 00
    enter(32'h31235958);
    chk("load_fields", 32'(fields_out), 32'h31235958);
    press(1, 0, 0, 0);
    ack("sec_up1", 8'h21, 8'h59);
    press(1, 0, 0, 0);
    ack("sec_up2", 8'h21, 8'h00);
    chk("sec_fields", 32'(fields_out), 32'h31235900);

    // left x3 to date, down wraps 01 -> 31, left wraps to 0
    enter(32'h01235900);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    chk("idx_after_left3", 32'(field_idx), 32'd3);
    press(0, 1, 0, 0);
    ack("date_down", 8'h24, 8'h31);
    press(0, 0, 1, 0);
    chk("idx_wrap", 32'(field_idx), 32'd0);
    press(0, 0, 0, 1);
    chk("idx_right_wrap", 32'(field_idx), 32'd3);

    // up and down in the same cycle: up wins, one write
    enter(32'h01121000);
    press(0, 0, 1, 0);
    r0 = req_count;
    press(1, 1, 0, 0);
    ack("updown_same", 8'h22, 8'h11);
    repeat (8) @(negedge clk);
    chk("updown_one_write", 32'(req_count - r0), 32'd1);

    // long handshake with a dropped press during the wait
    r0 = req_count;
    press(0, 1, 0, 0);
    wait_req("hold_start");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_wr_req", 32'(wr_req), 32'd1);
      chk("hold_data", 32'(data_mod), 32'h10);
      chk("hold_addr", 32'(address), 32'h22);
      if (i == 5) push_abajo = 1'b1;
      if (i == 6) push_abajo = 1'b0;
    end
    ack("hold_ack", 8'h22, 8'h10);
    repeat (10) @(negedge clk);
    chk("hold_one_write", 32'(req_count - r0), 32'd1);

    // reset in the middle of a commit
    press(1, 0, 0, 0);
    wait_req("rst_mid_start");
    @(posedge clk);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_wr_req", 32'(wr_req), 32'd0);
    chk("midrst_editing", 32'(editing), 32'd0);
    chk("midrst_address", 32'(address), 32'h21);
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    r0 = req_count;
    repeat (10) @(negedge clk);
    press(1, 0, 0, 0);
    repeat (10) @(negedge clk);
    chk("midrst_no_write", 32'(req_count - r0), 32'd0);
    chk("midrst_still_idle", 32'(editing), 32'd0);

    // invalid hour snapshot becomes FIELD_MIN
    enter(32'h013A1000);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    ack("bad_hour", 8'h23, 8'h00);
    chk("bad_hour_fields", 32'(fields_out), 32'h01001000);

    Escribir = 1'b0;
    repeat (6) @(negedge clk);
    chk("final_idle", 32'(editing), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rtc_field_editor.md
RTC_FIELD_EDITOR -- requirements
Module: rtc_field_editor

Interface
REQ-001 Parameter NUM_FIELDS, default 4, number of editable RTC fields (legal range 1..8).
REQ-002 Parameter BASE_ADDR, default 8'h21, RTC register address of field 0; field i maps to BASE_ADDR+i.
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser depth on button and Escribir inputs (legal range 2..3).
REQ-004 Port clk input 1: single clock; all state changes on its rising edge.
REQ-005 Port Reset input 1: asynchronous, active-high reset.
REQ-006 Port Escribir input 1: edit-mode enable level, asynchronous to clk.
REQ-007 Ports push_arriba, push_abajo, push_izquierda, push_derecha input 1 each: raw debounced buttons (increment, decrement, next field, previous field).
REQ-008 Port rd_data input NUM_FIELDS*8: current RTC values, packed BCD, field 0 in bits [7:0].
REQ-009 Port wr_ack input 1: one-cycle acknowledge from the RTC bus master.
REQ-010 Port address output 8: register address of the pending write.
REQ-011 Port data_mod output 8: BCD value of the pending write.
REQ-012 Port wr_req output 1: write request, held until acknowledged.
REQ-013 Port field_idx output 3: currently selected field.
REQ-014 Port fields_out output NUM_FIELDS*8: shadow copy of all fields, for display.
REQ-015 Port editing output 1: high in every state except IDLE.

Function
REQ-016 Inputs pass through SYNC_STAGES flops plus one history flop; a rising edge produces a one-cycle event pulse.
REQ-017 Priority of simultaneous events: up > down > left > right; lower-priority events in the same cycle are discarded.
REQ-018 States IDLE, LOAD, EDIT, COMMIT.
REQ-019 IDLE: on Escribir rising event -> LOAD; button events ignored.
REQ-020 LOAD (one cycle): shadow <= rd_data, field_idx <= 0; then -> EDIT.
REQ-021 EDIT, up: selected shadow field <= BCD+1; at FIELD_MAX it wraps to FIELD_MIN; then -> COMMIT.
REQ-022 EDIT, down: selected shadow field <= BCD-1; at FIELD_MIN it wraps to FIELD_MAX; then -> COMMIT.
REQ-023 An invalid snapshot value (nibble >9 or outside [FIELD_MIN, FIELD_MAX]) becomes FIELD_MIN on up or down.
REQ-024 EDIT, left: field_idx+1, wrapping from NUM_FIELDS-1 to 0; right: field_idx-1, wrapping from 0 to NUM_FIELDS-1; no write results.
REQ-025 The shadow update and the COMMIT entry occur on the same edge, 1 cycle after the event pulse.
REQ-026 In COMMIT: wr_req=1, address=BASE_ADDR+field_idx, data_mod=shadow[field_idx], all stable until wr_ack is sampled high; then wr_req=0 and -> EDIT on the same edge.
REQ-027 Button events arriving in COMMIT are dropped, not queued.
REQ-028 Escribir falling in EDIT -> IDLE; in COMMIT, the handshake completes first, then -> IDLE.
REQ-029 wr_ack outside COMMIT is ignored.
REQ-030 Outside COMMIT, wr_req=0 and address/data_mod hold their last values.

Reset
REQ-031 Reset asynchronously forces: IDLE, wr_req=0, address=BASE_ADDR, data_mod=8'h00, field_idx=0, shadow=0, editing=0, all sync/history flops 0.
REQ-032 Reset mid-COMMIT abandons the write with no further wr_req; first post-reset edit requires a fresh Escribir rising edge.

Structure
REQ-033 Shared package rtc_pkg holds the state enumeration and FIELD_MIN/FIELD_MAX tables for indices 0..7:
- sec 00-59
- min 00-59
- hour 00-23
- date 01-31
- month 01-12
- year 00-99
- day-of-week 01-07
- week 01-53
REQ-034 BCD increment/decrement-with-wrap is one combinational sub-module, bcd_step (inputs: value, min, max, dir; output: next value).

Verification
REQ-035 Escribir rise, rd_data={date 8'h31, hr 8'h23, min 8'h59, sec 8'h58}; up x2 on sec -> writes (8'h21, 8'h59) then (8'h21, 8'h00).
REQ-036 left x3 then down on date 8'h01 -> write (8'h24, 8'h31); one further left -> field_idx=0.
REQ-037 Up and down pulsed in the same cycle on min 8'h10 -> only (8'h22, 8'h11) written.
REQ-038 wr_ack held low 20 cycles with a down press during the wait -> wr_req and data held all 20 cycles, one write only.
REQ-039 Reset asserted mid-COMMIT -> wr_req=0 asynchronously, state IDLE, address=8'h21; a later button press with Escribir high and no new rising edge -> no write.
REQ-040 Snapshot hour 8'h3A, up -> write (8'h23, 8'h00).
